// File: rtl/sraml_arbiter_pkg.sv
// sraml_pkg: master IDs and access-size encodings shared by the arbiter, its ID FIFO and benches
package sraml_pkg;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
endpackage

// File: rtl/sraml_arbiter_if.sv
// sraml_if: sram-like bus; master drives req/wr/size/addr/wdata, slave returns addr_ok/data_ok/rdata
interface sraml_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sraml_id_fifo.sv
// sraml_id_fifo: 1-bit owner-ID FIFO, DEPTH deep; ports clk, rst (async low), i_push/i_din, i_pop, o_head/o_empty/o_full
module sraml_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_head,
  output logic o_empty,
  output logic o_full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  always_comb begin
    o_empty = r_count == '0;
    o_full  = r_count == CW'(DEPTH);
    o_head  = r_mem[r_rd_ptr];
    w_push  = i_push & ~o_full;
    w_pop   = i_pop & ~o_empty;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_mem    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= nxt(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= nxt(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/sraml_arbiter.sv
// sraml_arbiter: round-robin share of one sram-like slave between inst and data masters; ports clk, rst (async low), inst/data (slave modports), s (master modport)
module sraml_arbiter
  import sraml_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic     clk,
  input  logic     rst,
  sraml_if.slave   inst,
  sraml_if.slave   data,
  sraml_if.master  s
);
  logic r_last_grant, r_lock_valid, r_lock_id;
  logic w_sel, w_sel_req, w_accept, w_pop, w_head, w_empty, w_full;
  sraml_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_din   (w_sel),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );
  always_comb begin
    w_sel         = r_lock_valid ? r_lock_id : (inst.req & data.req) ? ~r_last_grant : data.req;
    w_sel_req     = w_sel ? data.req : inst.req;
    s.req         = rst & w_sel_req & ~w_full;
    s.wr          = w_sel ? data.wr : inst.wr;
    s.size        = w_sel ? data.size : inst.size;
    s.addr        = w_sel ? data.addr : inst.addr;
    s.wdata       = w_sel ? data.wdata : inst.wdata;
    w_accept      = s.req & s.addr_ok;
    w_pop         = rst & s.data_ok & ~w_empty;
    inst.addr_ok  = w_accept & (w_sel == ID_INST);
    data.addr_ok  = w_accept & (w_sel == ID_DATA);
    inst.data_ok  = w_pop & (w_head == ID_INST);
    data.data_ok  = w_pop & (w_head == ID_DATA);
    inst.rdata    = s.rdata;
    data.rdata    = s.rdata;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_last_grant <= ID_DATA;
      r_lock_valid <= 1'b0;
      r_lock_id    <= ID_INST;
    end else if (w_accept) begin
      r_last_grant <= w_sel;
      r_lock_valid <= 1'b0;
    end else if (s.req) begin
      r_lock_valid <= 1'b1;
      r_lock_id    <= w_sel;
    end else if (r_lock_valid & ~w_sel_req & ~w_full)
      r_lock_valid <= 1'b0;
endmodule

// File: tb/tb_sraml_arbiter.sv
// tb_sraml_arbiter: directed and random stimulus for sraml_arbiter against a queue-based owner model
module tb_sraml_arbiter;
  import sraml_pkg::*;
  localparam int MAX = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  sraml_if inst_if ();
  sraml_if data_if ();
  sraml_if s_if ();
  sraml_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_if),
    .data (data_if),
    .s    (s_if)
  );
  int n_cmp = 0;
  int n_err = 0;
  logic        m_req[2], m_wr[2];
  logic [1:0]  m_size[2];
  logic [31:0] m_addr[2], m_wdata[2];
  logic        sl_aok, sl_dok;
  logic [31:0] sl_rdata;
  int  owners[$];
  int  last_grant, lock_id;
  bit  lock_v;
  bit  e_aok[2];
  logic obs_sreq, obs_idok, obs_ddok;
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    owners.delete();
    last_grant = 1;
    lock_v = 0;
    lock_id = 0;
  endtask
  task automatic step();
    int sel, n;
    bit sreq;
    bit dok[2];
    inst_if.req = m_req[0]; inst_if.wr = m_wr[0]; inst_if.size = m_size[0];
    inst_if.addr = m_addr[0]; inst_if.wdata = m_wdata[0];
    data_if.req = m_req[1]; data_if.wr = m_wr[1]; data_if.size = m_size[1];
    data_if.addr = m_addr[1]; data_if.wdata = m_wdata[1];
    s_if.addr_ok = sl_aok; s_if.data_ok = sl_dok; s_if.rdata = sl_rdata;
    #1;
    if (!rst) model_reset();
    n = owners.size();
    if (lock_v) sel = lock_id;
    else if (m_req[0] && m_req[1]) sel = 1 - last_grant;
    else if (m_req[1]) sel = 1;
    else sel = 0;
    sreq = rst && m_req[sel] && n < MAX;
    for (int i = 0; i < 2; i++) begin
      e_aok[i] = sreq && sl_aok && sel == i;
      dok[i] = rst && sl_dok && n > 0 && owners[0] == i;
    end
    obs_sreq = s_if.req;
    obs_idok = inst_if.data_ok;
    obs_ddok = data_if.data_ok;
    check("s_req", s_if.req, sreq);
    check("s_wr", s_if.wr, m_wr[sel]);
    check("s_size", s_if.size, m_size[sel]);
    check("s_addr", s_if.addr, m_addr[sel]);
    check("s_wdata", s_if.wdata, m_wdata[sel]);
    check("inst_addr_ok", inst_if.addr_ok, e_aok[0]);
    check("data_addr_ok", data_if.addr_ok, e_aok[1]);
    check("inst_data_ok", inst_if.data_ok, dok[0]);
    check("data_data_ok", data_if.data_ok, dok[1]);
    check("inst_rdata", inst_if.rdata, sl_rdata);
    check("data_rdata", data_if.rdata, sl_rdata);
    @(posedge clk);
    if (rst) begin
      if (dok[0] || dok[1]) void'(owners.pop_front());
      if (sreq && sl_aok) begin
        owners.push_back(sel);
        last_grant = sel;
        lock_v = 0;
      end else if (sreq) begin
        lock_v = 1;
        lock_id = sel;
      end else if (lock_v && !m_req[lock_id] && n < MAX) lock_v = 0;
    end
    for (int i = 0; i < 2; i++) if (e_aok[i]) m_req[i] = 0;
    @(negedge clk);
  endtask
  task automatic rand_stim();
    for (int i = 0; i < 2; i++) begin
      if (!m_req[i] && $urandom_range(0, 1) == 1) begin
        m_req[i] = 1;
        m_wr[i] = 1'($urandom_range(0, 1));
        m_size[i] = 2'($urandom_range(0, 2));
        m_addr[i] = $urandom;
        m_wdata[i] = $urandom;
      end else if (m_req[i] && $urandom_range(0, 31) == 0) m_req[i] = 0;
    end
    sl_aok = $urandom_range(0, 2) != 0;
    sl_dok = $urandom_range(0, 2) == 0;
    sl_rdata = $urandom;
  endtask
  task automatic idle();
    m_req[0] = 0; m_req[1] = 0; sl_aok = 0; sl_dok = 0;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 0; m_wr[i] = 0; m_size[i] = SIZE_WORD; m_addr[i] = 0; m_wdata[i] = 0;
    end
    sl_aok = 0; sl_dok = 0; sl_rdata = 0;
    model_reset();
    @(negedge clk);
    step(); step();
    rst = 1;
    m_req[0] = 1; m_addr[0] = 32'h1FC00000;
    step();
    sl_aok = 1;
    step();
    idle();
    step();
    sl_dok = 1; sl_rdata = 32'h3C1D0000;
    step();
    check("single_read_data_ok", obs_idok, 1'b1);
    idle();
    m_req[0] = 1; m_addr[0] = 32'h00001000;
    m_req[1] = 1; m_addr[1] = 32'h80002000;
    sl_aok = 1;
    step();
    m_req[0] = 1; sl_dok = 1;
    step();
    m_req[1] = 1;
    step();
    idle(); sl_dok = 1;
    step(); step();
    idle();
    m_req[1] = 1; m_addr[1] = 32'h80004000;
    step();
    m_req[0] = 1; m_addr[0] = 32'h00004000;
    step(); step();
    sl_aok = 1;
    step();
    step();
    idle(); sl_dok = 1;
    step(); step();
    idle();
    sl_aok = 1; m_req[0] = 1;
    step();
    m_req[1] = 1;
    step();
    m_req[0] = 1;
    step();
    check("full_blocks_s_req", obs_sreq, 1'b0);
    sl_dok = 1; sl_rdata = 32'h0000AAAA;
    step();
    check("full_first_owner_inst", obs_idok, 1'b1);
    sl_rdata = 32'h0000BBBB;
    step();
    check("full_second_owner_data", obs_ddok, 1'b1);
    sl_rdata = 32'h0000CCCC;
    step();
    check("pushpop_owner_inst", obs_idok, 1'b1);
    idle();
    sl_aok = 1; m_req[0] = 1;
    step();
    m_req[1] = 1;
    step();
    idle();
    rst = 0;
    step();
    rst = 1; sl_dok = 1;
    step();
    check("stray_inst_data_ok", obs_idok, 1'b0);
    check("stray_data_data_ok", obs_ddok, 1'b0);
    sl_dok = 0;
    step();
    for (int c = 0; c < 4000; c++) begin
      rand_stim();
      rst = $urandom_range(0, 299) != 0;
      step();
    end
    rst = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
